// File: rtl/lectura_de_parametros.sv
// lectura_de_parametros: sweeps the nine RTC time/date/timer registers over the multiplexed bus and holds the BCD bytes read
module lectura_de_parametros #(
   parameter int T_FASE = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       EN,
   input  logic [7:0] Dato_in,
   output logic [7:0] Dir,
   output logic       Dir_oe,
   output logic       AD,
   output logic       CS,
   output logic       RD,
   output logic       WR,
   output logic [7:0] s,
   output logic [7:0] m,
   output logic [7:0] h,
   output logic [7:0] d,
   output logic [7:0] me,
   output logic [7:0] a,
   output logic [7:0] st,
   output logic [7:0] mt,
   output logic [7:0] ht,
   output logic       Listo_le
);
   typedef enum logic [2:0] {IDLE, A_WR, A_GAP, D_RD, D_GAP, DONE} estado_t;
   estado_t    r_est, w_sig;
   logic [7:0] r_cnt;
   logic [3:0] r_idx;
   logic [7:0] r_dat [9];
   logic       w_fin, w_ad, w_cs, w_rd, w_wr, w_oe;
   logic [7:0] w_dir;

   assign w_fin = r_cnt == 8'(T_FASE - 1);
   assign w_dir = (r_idx < 4'd6) ? 8'h21 + {4'd0, r_idx} : 8'h3b + {4'd0, r_idx};

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_est <= IDLE;
         r_cnt <= '0;
         r_idx <= '0;
      end else begin
         r_est <= w_sig;
         r_cnt <= (w_sig != r_est || r_est == IDLE) ? 8'd0 : r_cnt + 8'd1;
         r_idx <= (r_est == IDLE) ? 4'd0 :
                  (r_est == D_GAP && w_fin && w_sig == A_WR) ? r_idx + 4'd1 : r_idx;
      end

   always_comb begin
      w_sig = r_est;
      case (r_est)
         IDLE:    w_sig = EN ? A_WR : IDLE;
         A_WR:    w_sig = w_fin ? A_GAP : A_WR;
         A_GAP:   w_sig = w_fin ? D_RD : A_GAP;
         D_RD:    w_sig = w_fin ? D_GAP : D_RD;
         D_GAP:   w_sig = !w_fin ? D_GAP : (r_idx == 4'd8) ? DONE : EN ? A_WR : IDLE;
         default: w_sig = IDLE;
      endcase
   end

   // bus strobes follow the current state and are registered, so they trail it by one clock
   always_comb begin
      w_ad = r_est != A_WR;
      w_wr = r_est != A_WR;
      w_rd = r_est != D_RD;
      w_cs = !(r_est == A_WR || r_est == D_RD);
      w_oe = r_est == A_WR || r_est == A_GAP;
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         AD       <= 1'b1;
         CS       <= 1'b1;
         RD       <= 1'b1;
         WR       <= 1'b1;
         Dir      <= 8'h00;
         Dir_oe   <= 1'b0;
         Listo_le <= 1'b0;
         r_dat    <= '{default: 8'h00};
      end else begin
         AD       <= w_ad;
         CS       <= w_cs;
         RD       <= w_rd;
         WR       <= w_wr;
         Dir      <= (r_est == A_WR) ? w_dir : Dir;
         Dir_oe   <= w_oe;
         Listo_le <= r_est == DONE;
         if (r_est == D_RD && w_fin) r_dat[r_idx] <= Dato_in;
      end

   assign s  = r_dat[0];
   assign m  = r_dat[1];
   assign h  = r_dat[2];
   assign d  = r_dat[3];
   assign me = r_dat[4];
   assign a  = r_dat[5];
   assign st = r_dat[6];
   assign mt = r_dat[7];
   assign ht = r_dat[8];
endmodule

// File: tb/tb_lectura_de_parametros.sv
// tb_lectura_de_parametros: RTC bus model, vector table and randomized sweeps for lectura_de_parametros
module tb_lectura_de_parametros;
   localparam int TF = 4;
   localparam logic [7:0]  ADDR [9] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};
   localparam logic [71:0] PLAN = 72'h23_10_11_18_01_16_59_59_21;
   localparam logic [85:0] RST_SNAP = {6'b111100, 80'h0};
   typedef struct packed {
      logic [71:0] val;
      logic [71:0] exp;
   } vec_t;

   logic clk = 1'b0, rst = 1'b1, EN = 1'b1;
   logic [7:0] Dato_in, Dir, s, m, h, d, me, a, st, mt, ht;
   logic Dir_oe, AD, CS, RD, WR, Listo_le;
   logic [7:0] rtc [256];
   logic [7:0] r_lat = 8'h00;
   logic [71:0] outs;
   logic [85:0] snap;
   logic [12:0] trace [$];
   vec_t tbl [4];
   int checks = 0, errors = 0, listo_cnt = 0, ovl = 0;

   lectura_de_parametros #(.T_FASE(TF)) dut (
      .clk(clk), .rst(rst), .EN(EN), .Dato_in(Dato_in), .Dir(Dir), .Dir_oe(Dir_oe),
      .AD(AD), .CS(CS), .RD(RD), .WR(WR), .s(s), .m(m), .h(h), .d(d), .me(me), .a(a),
      .st(st), .mt(mt), .ht(ht), .Listo_le(Listo_le)
   );

   always #5 clk = ~clk;

   // RTC: latches the address on the address phase, drives its register while RD and CS are low
   always @(posedge clk) if (!CS && !WR && !AD) r_lat <= Dir;
   assign Dato_in = (!CS && !RD) ? rtc[r_lat] : 8'hff;
   assign outs = {s, m, h, d, me, a, st, mt, ht};
   assign snap = {AD, CS, RD, WR, Dir_oe, Listo_le, Dir, outs};

   always @(negedge clk)
      if (!rst) begin
         if (!WR && !RD) ovl++;
         if (Dir_oe && !RD) ovl++;
         if (Listo_le) listo_cnt++;
      end

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", nm, act, exp);
      end
   endtask

   function automatic logic [7:0] byte_of(input logic [71:0] v, input int i);
      return v[71-8*i -: 8];
   endfunction

   task automatic load(input logic [71:0] v);
      for (int i = 0; i < 9; i++) rtc[ADDR[i]] = byte_of(v, i);
   endtask

   task automatic run_sweep(input logic [71:0] want, input string tag);
      int n, na;
      trace.delete();
      @(negedge clk);
      EN = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         trace.push_back({AD, CS, RD, WR, Dir_oe, Dir});
      end while (!Listo_le && n < 400);
      EN = 1'b0;
      chk({tag, " latency"}, 128'(n - 1), 128'(36*TF + 1));
      @(negedge clk);
      chk({tag, " pulse"}, 128'(Listo_le), 128'(0));
      for (int i = 0; i < 9; i++)
         chk($sformatf("%s reg%0d", tag, i), 128'(byte_of(outs, i)), 128'(byte_of(want, i)));
      na = 0;
      for (int k = 1; k < trace.size(); k++)
         if (!trace[k][9] && trace[k-1][9]) begin
            if (na < 9) chk($sformatf("%s addr%0d", tag, na), 128'(trace[k][7:0]), 128'(ADDR[na]));
            na++;
         end
      chk({tag, " naddr"}, 128'(na), 128'(9));
   endtask

   initial begin
      int n, l0;
      logic [71:0] v;
      logic [4:0] e;
      for (int i = 0; i < 256; i++) rtc[i] = 8'h00;
      tbl[0] = '{val: 72'h23_10_11_18_01_16_59_59_21, exp: 72'h23_10_11_18_01_16_59_59_21};
      tbl[1] = '{val: 72'h00_00_00_01_01_00_00_00_00, exp: 72'h00_00_00_01_01_00_00_00_00};
      tbl[2] = '{val: 72'h59_59_23_31_12_99_59_59_23, exp: 72'h59_59_23_31_12_99_59_59_23};
      tbl[3] = '{val: 72'h5a_a5_ff_00_80_01_7e_e7_3c, exp: 72'h5a_a5_ff_00_80_01_7e_e7_3c};

      repeat (9) begin
         @(negedge clk);
         chk("reset hold", 128'(snap), 128'(RST_SNAP));
      end
      @(negedge clk);
      rst = 1'b0;
      EN = 1'b0;
      #1 chk("reset release", 128'(snap), 128'(RST_SNAP));

      load(PLAN);
      run_sweep(PLAN, "plan");
      for (int k = 0; k < 14; k++) begin
         e = (k == 0 || k == 13) ? 5'b11110 : (k < 5) ? 5'b00101 : (k < 9) ? 5'b11111 : 5'b10010;
         chk($sformatf("bus cycle%0d", k), 128'(trace[k][12:8]), 128'(e));
         if (k >= 1 && k <= 8) chk($sformatf("bus dir%0d", k), 128'(trace[k][7:0]), 128'(8'h21));
      end

      for (int t = 0; t < 4; t++) begin
         load(tbl[t].val);
         run_sweep(tbl[t].exp, $sformatf("tbl%0d", t));
      end
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < 9; i++) v[71-8*i -: 8] = 8'($urandom_range(0, 255));
         load(v);
         repeat ($urandom_range(0, 5)) @(negedge clk);
         run_sweep(v, $sformatf("rand%0d", r));
      end
      chk("strobe overlap", 128'(ovl), 128'(0));

      @(negedge clk) rst = 1'b1;
      @(negedge clk) rst = 1'b0;
      load(PLAN);
      l0 = listo_cnt;
      @(negedge clk) EN = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(!RD && Dir == 8'h22) && n < 400);
      chk("abort reach", 128'(n < 400), 128'(1));
      EN = 1'b0;
      repeat (3*TF + 4) @(negedge clk);
      chk("abort bus", 128'({AD, CS, RD, WR, Dir_oe}), 128'(5'b11110));
      chk("abort regs", 128'(outs), 128'({8'h23, 8'h10, 56'h0}));
      chk("abort listo", 128'(listo_cnt), 128'(l0));

      @(negedge clk) EN = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(!RD && Dir == 8'h23) && n < 400);
      chk("midrst reach", 128'(n < 400), 128'(1));
      #2 rst = 1'b1;
      #1 chk("midrst async", 128'(snap), 128'(RST_SNAP));
      @(negedge clk) rst = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (WR && n < 20);
      chk("restart addr", 128'({!WR, Dir}), 128'({1'b1, 8'h21}));
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!Listo_le && n < 400);
      chk("restart sweep", 128'(outs), 128'(PLAN));

      rtc[8'h21] = 8'h24;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (WR && n < 20);
      chk("resweep gap", 128'(n), 128'(2));
      chk("resweep addr", 128'(Dir), 128'(8'h21));
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (RD && n < 40);
      do begin
         @(negedge clk);
         n++;
      end while (!RD && n < 40);
      chk("resweep s", 128'(s), 128'(8'h24));
      EN = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
